// File: rtl/lcd_timing_pkg.sv
// Shared LCD timing definitions: default raster geometry, bus widths and FSM encoding.
package lcd_timing_pkg;

    // Default panel geometry (480x272 class panel)
    localparam int LCD_H_SYNC  = 41;
    localparam int LCD_H_BACK  = 2;
    localparam int LCD_H_DISP  = 480;
    localparam int LCD_H_FRONT = 2;
    localparam int LCD_V_SYNC  = 10;
    localparam int LCD_V_BACK  = 2;
    localparam int LCD_V_DISP  = 272;
    localparam int LCD_V_FRONT = 2;

    localparam int LCD_H_TOTAL = LCD_H_SYNC + LCD_H_BACK + LCD_H_DISP + LCD_H_FRONT;
    localparam int LCD_V_TOTAL = LCD_V_SYNC + LCD_V_BACK + LCD_V_DISP + LCD_V_FRONT;
    localparam int LCD_HA      = LCD_H_SYNC + LCD_H_BACK;
    localparam int LCD_VA      = LCD_V_SYNC + LCD_V_BACK;

    localparam int LCD_CNT_W   = 11;
    localparam int LCD_RGB_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } lcd_state_e;

    // Half-open window test: lo <= c < hi
    function automatic logic in_window(input logic [LCD_CNT_W-1:0] c,
                                       input logic [LCD_CNT_W-1:0] lo,
                                       input logic [LCD_CNT_W-1:0] hi);
        return (c >= lo) && (c < hi);
    endfunction

endpackage

// File: rtl/lcd_raster_cnt.sv
// Horizontal/vertical raster counters with synchronous clear and wrap flags.
module lcd_raster_cnt
    import lcd_timing_pkg::*;
#(
    parameter int H_TOTAL = LCD_H_TOTAL,
    parameter int V_TOTAL = LCD_V_TOTAL
) (
    input  logic                 lcd_pclk,
    input  logic                 rst_n,
    input  logic                 clr,
    output logic [LCD_CNT_W-1:0] h_cnt,
    output logic [LCD_CNT_W-1:0] v_cnt,
    output logic                 frame_wrap
);

    localparam logic [LCD_CNT_W-1:0] H_LAST = LCD_CNT_W'(H_TOTAL - 1);
    localparam logic [LCD_CNT_W-1:0] V_LAST = LCD_CNT_W'(V_TOTAL - 1);

    logic [LCD_CNT_W-1:0] h_cnt_r;
    logic [LCD_CNT_W-1:0] v_cnt_r;
    logic                 h_wrap_s;

    assign h_wrap_s   = (h_cnt_r == H_LAST);
    assign frame_wrap = h_wrap_s && (v_cnt_r == V_LAST);
    assign h_cnt      = h_cnt_r;
    assign v_cnt      = v_cnt_r;

    // Advance h every cycle, v on each h wrap; clear holds both at the origin
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_r <= {LCD_CNT_W{1'b0}};
            v_cnt_r <= {LCD_CNT_W{1'b0}};
        end else if (clr) begin
            h_cnt_r <= {LCD_CNT_W{1'b0}};
            v_cnt_r <= {LCD_CNT_W{1'b0}};
        end else if (h_wrap_s) begin
            h_cnt_r <= {LCD_CNT_W{1'b0}};
            if (v_cnt_r == V_LAST) begin
                v_cnt_r <= {LCD_CNT_W{1'b0}};
            end else begin
                v_cnt_r <= v_cnt_r + 11'd1;
            end
        end else begin
            h_cnt_r <= h_cnt_r + 11'd1;
        end
    end

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD raster timing generator: scan FSM, pixel coordinate request and
// one-stage alignment of sync/DE with the pixel source's returned data.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int   H_SYNC   = LCD_H_SYNC,
    parameter int   H_BACK   = LCD_H_BACK,
    parameter int   H_DISP   = LCD_H_DISP,
    parameter int   H_FRONT  = LCD_H_FRONT,
    parameter int   V_SYNC   = LCD_V_SYNC,
    parameter int   V_BACK   = LCD_V_BACK,
    parameter int   V_DISP   = LCD_V_DISP,
    parameter int   V_FRONT  = LCD_V_FRONT,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic                 lcd_pclk,
    input  logic                 rst_n,
    input  logic                 disp_en,
    input  logic [LCD_RGB_W-1:0] pixel_data,
    output logic [LCD_CNT_W-1:0] pixel_xpos,
    output logic [LCD_CNT_W-1:0] pixel_ypos,
    output logic                 data_req,
    output logic                 lcd_hs,
    output logic                 lcd_vs,
    output logic                 lcd_de,
    output logic [LCD_RGB_W-1:0] lcd_rgb,
    output logic                 frame_start,
    output logic                 busy
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int HA      = H_SYNC + H_BACK;
    localparam int VA      = V_SYNC + V_BACK;

    // The request leads the active window by one pixel to cover the source latency
    localparam logic [LCD_CNT_W-1:0] HREQ_LO = LCD_CNT_W'(HA - 1);
    localparam logic [LCD_CNT_W-1:0] HREQ_HI = LCD_CNT_W'(HA + H_DISP - 1);
    localparam logic [LCD_CNT_W-1:0] VREQ_LO = LCD_CNT_W'(VA);
    localparam logic [LCD_CNT_W-1:0] VREQ_HI = LCD_CNT_W'(VA + V_DISP);
    localparam logic [LCD_CNT_W-1:0] HS_END  = LCD_CNT_W'(H_SYNC);
    localparam logic [LCD_CNT_W-1:0] VS_END  = LCD_CNT_W'(V_SYNC);

    lcd_state_e           state_r;
    lcd_state_e           state_s;
    logic                 active_s;
    logic [LCD_CNT_W-1:0] h_cnt_s;
    logic [LCD_CNT_W-1:0] v_cnt_s;
    logic                 frame_wrap_s;
    logic                 data_req_s;
    logic [LCD_CNT_W-1:0] xpos_s;
    logic [LCD_CNT_W-1:0] ypos_s;
    logic                 de_r;
    logic                 hs_raw_r;
    logic                 vs_raw_r;
    logic                 frame_start_r;

    assign active_s = (state_r != ST_IDLE);

    lcd_raster_cnt #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_cnt (
        .lcd_pclk   (lcd_pclk),
        .rst_n      (rst_n),
        .clr        (~active_s),
        .h_cnt      (h_cnt_s),
        .v_cnt      (v_cnt_s),
        .frame_wrap (frame_wrap_s)
    );

    // Scan state register
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state: stops only on the last pixel of a frame, re-enable cancels a stop
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (disp_en) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!disp_en) begin
                    state_s = ST_STOPPING;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_STOPPING: begin
                if (disp_en) begin
                    state_s = ST_RUN;
                end else if (frame_wrap_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_STOPPING;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Coordinate request decode; coordinates are forced to 0 outside the window
    always_comb begin
        data_req_s = 1'b0;
        xpos_s     = {LCD_CNT_W{1'b0}};
        ypos_s     = {LCD_CNT_W{1'b0}};
        if (active_s && in_window(h_cnt_s, HREQ_LO, HREQ_HI)
                     && in_window(v_cnt_s, VREQ_LO, VREQ_HI)) begin
            data_req_s = 1'b1;
            xpos_s     = h_cnt_s - HREQ_LO;
            ypos_s     = v_cnt_s - VREQ_LO;
        end else begin
            data_req_s = 1'b0;
            xpos_s     = {LCD_CNT_W{1'b0}};
            ypos_s     = {LCD_CNT_W{1'b0}};
        end
    end

    // Alignment stage: delay DE/sync by one pclk to match the returned pixel data
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            de_r          <= 1'b0;
            hs_raw_r      <= 1'b0;
            vs_raw_r      <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            de_r          <= data_req_s;
            hs_raw_r      <= active_s && (h_cnt_s < HS_END);
            vs_raw_r      <= active_s && (v_cnt_s < VS_END);
            frame_start_r <= active_s && (h_cnt_s == 11'd0) && (v_cnt_s == 11'd0);
        end
    end

    assign data_req    = data_req_s;
    assign pixel_xpos  = xpos_s;
    assign pixel_ypos  = ypos_s;
    assign lcd_de      = de_r;
    assign lcd_hs      = hs_raw_r ^ ~SYNC_POL;
    assign lcd_vs      = vs_raw_r ^ ~SYNC_POL;
    assign lcd_rgb     = de_r ? pixel_data : 16'h0000;
    assign frame_start = frame_start_r;
    assign busy        = active_s;

endmodule

// File: doc/lcd_timing_gen.md
Name: lcd_timing_gen

Overview:
Upstream neighbour of the colour-bar/pixel source on the LCD path.
- Generates the raster counters, the per-pixel coordinate request (pixel_xpos/pixel_ypos) and the panel sync/DE signals.
- Accepts the 16-bit RGB565 pixel_data that the pixel source returns exactly one lcd_pclk later.
- Aligns that data with the sync/DE signals and drives the panel bus.
- Supports clean start/stop of scanning on frame boundaries.

Parameters:
H_SYNC, 41, hsync width in pclk
H_BACK, 2, horizontal back porch
H_DISP, 480, active pixels per line
H_FRONT, 2, horizontal front porch
V_SYNC, 10, vsync width in lines
V_BACK, 2, vertical back porch
V_DISP, 272, active lines
V_FRONT, 2, vertical front porch
SYNC_POL, 0, active level of lcd_hs/lcd_vs (0 = active-low)

Ports:
lcd_pclk  in  1  pixel clock; only clock
rst_n  in  1  asynchronous active-low reset
disp_en  in  1  request scanning; sampled every cycle
pixel_data  in  16  RGB565 from pixel source, registered there (1-cycle latency)
pixel_xpos  out  11  requested column, 0..H_DISP-1
pixel_ypos  out  11  requested row, 0..V_DISP-1
data_req  out  1  coordinates valid this cycle
lcd_hs  out  1  horizontal sync
lcd_vs  out  1  vertical sync
lcd_de  out  1  data enable
lcd_rgb  out  16  panel pixel bus
frame_start  out  1  one-cycle pulse at raster origin
busy  out  1  high while not IDLE

Behaviour:
- Derived constants:
  - H_TOTAL = sum of H_*
  - V_TOTAL = sum of V_*
  - HA = H_SYNC+H_BACK (first active h_cnt)
  - VA = V_SYNC+V_BACK
- Counters (11-bit, registered):
  - h_cnt runs 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps; it runs 0..V_TOTAL-1 and wraps to 0.
- FSM states IDLE, RUN, STOPPING.
  - IDLE: counters held at 0; all outputs inactive. disp_en=1 → RUN next cycle; counting starts from (0,0).
  - RUN: counters advance. disp_en=0 → STOPPING.
  - STOPPING: counters advance. At (H_TOTAL-1, V_TOTAL-1) → IDLE. If disp_en returns to 1 before that point → RUN; the frame is not interrupted.
  - A frame is never truncated.
- data_req (combinational from counters, state≠IDLE):
  - Asserted when h_cnt in [HA-1, HA+H_DISP-1) and v_cnt in [VA, VA+V_DISP).
- pixel_xpos/pixel_ypos:
  - When data_req: pixel_xpos = h_cnt-(HA-1), pixel_ypos = v_cnt-VA.
  - Otherwise both are 0.
  - No bit growth beyond 11 bits; parameters must keep H_TOTAL, V_TOTAL ≤ 2047.
- Alignment registers (one stage):
  - lcd_de = data_req delayed 1.
  - hs_raw = (h_cnt < H_SYNC); vs_raw = (v_cnt < V_SYNC). Both delayed 1, then XORed with ~SYNC_POL for output polarity.
  - In IDLE, hs/vs are held at the inactive level.
- lcd_rgb = lcd_de ? pixel_data : 16'h0000. This is a combinational gate only; it adds no latency.
- frame_start: registered. High for exactly one cycle when the counters equal (0,0) in RUN/STOPPING. This includes the first cycle after leaving IDLE.
- busy = (state≠IDLE).
- Reset (asynchronous, any time, including mid-frame):
  - state=IDLE, counters 0, lcd_de=0, hs/vs inactive, frame_start=0.
  - data_req=0, pixel_xpos=pixel_ypos=0, lcd_rgb=0.
  - After release, scanning resumes only through disp_en from (0,0).
- Simultaneous events: an h wrap and a v wrap in the same cycle produce (0,0). In STOPPING this cycle is the IDLE transition, and no frame_start is issued.

Decomposition:
- Shared package/include `lcd_timing` holds:
  - default H_*/V_* constants and derived H_TOTAL/V_TOTAL/HA/VA;
  - RGB565 width constant;
  - FSM state encoding (2-bit: IDLE=0, RUN=1, STOPPING=2).
- One natural sub-module: lcd_raster_cnt, containing the h/v counters with hold/clear and the wrap flags. The FSM, request decode and alignment stage stay in the top.

Test Plan:
Small parameters: H 2/3/8/2 (H_TOTAL=15, HA=5), V 1/2/4/1 (V_TOTAL=8, VA=3), SYNC_POL=0. Bench pixel source = registered {5'b0, y[5:0], x[4:0]}.
- Idle after reset: disp_en=0 for 200 cycles → busy=0, lcd_de=0, lcd_hs=lcd_vs=1, lcd_rgb=0.
- Line timing: disp_en=1.
  - On row v_cnt=3, data_req is high for h_cnt 4..11 with pixel_xpos 0..7 and pixel_ypos=0.
  - lcd_de is high for h_cnt 5..12.
  - lcd_rgb equals the model for x=0..7, y=0.
- Frame timing: exactly 4 lines carry 8 DE cycles each per 120-cycle frame. lcd_vs is low for 15 cycles, starting one cycle after (0,0). frame_start pulses every 120 cycles.
- Graceful stop: drop disp_en at v_cnt=4 → the frame completes all 4 active lines, then busy falls at cycle 120 and no further frame_start.
- Stop cancel: drop disp_en then re-raise it within the same frame → no gap; next frame_start arrives exactly 120 cycles after the previous one.
- Reset mid-line: assert rst_n=0 at h_cnt=7, v_cnt=4 → all outputs go to reset values immediately (asynchronous). After release with disp_en=1, the first frame_start follows one cycle after the RUN entry, with counters at (0,0).
